mux5_bus_arbiter: RTL
=====================

# mux5_bus_arbiter

Round-robin arbiter and sequencer for the 5-input result-select mux in the ALU datapath. It takes up to five requesters that each drive one mux input and grants the mux to one of them at a time. It produces the one-hot grant and the matching 3-bit select code (000–100), with bounded hold time and a dead cycle between owners. All outputs are registered.

## Interface
- `HOLD_MAX`, default 15: maximum cycles a grant may be held before a forced release; legal range 1–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in 5: `req[i]` high = requester i wants the mux; level-sensitive.
- `done` in 1: the current owner finished; sampled only in GRANT.
- `grant` out 5: one-hot grant, or all-zero.
- `sel` out 3: mux select; encoding i = binary index of the granted requester (000..100).
- `busy` out 1: high while in GRANT or RELEASE.
- `timeout` out 1: one-cycle pulse when a grant is force-released.

## Operation
- Reset values:
  - state IDLE, `grant`=00000, `sel`=000, `busy`=0, `timeout`=0.
  - Internal: round-robin pointer `ptr`=0, hold counter `cnt`=0.
- State IDLE:
  - If `req`=0, stay in IDLE.
  - Otherwise the winner is the first index with `req` high, searching `ptr`, `ptr`+1, …, wrapping modulo 5.
  - Next state GRANT: `grant`=one-hot(winner), `sel`=winner, `busy`=1, `cnt`=1.
  - `ptr` becomes (winner+1) mod 5, with wrap 4→0.
- State GRANT, evaluated on each edge in this priority order:
  - `done`=1, or `req[owner]`=0 → RELEASE, `timeout`=0.
  - Else `cnt`==`HOLD_MAX` → RELEASE with `timeout`=1 for exactly one cycle.
  - Else stay in GRANT, `cnt`=`cnt`+1. `cnt` never exceeds `HOLD_MAX`; it is 4 bits.
- State RELEASE (one cycle):
  - `grant`=00000, `busy`=1; `sel` holds the previous owner's code so the mux output does not glitch.
  - Next state is IDLE unconditionally.
- `sel` retains its last value in IDLE and RELEASE.
- `sel` never takes the values 101–111.
- `grant` is never multi-hot.
- Requests that change in GRANT or RELEASE do not affect the current owner. They are arbitrated at the next IDLE.
- The owner's own request still high at IDLE competes normally. Because `ptr` has advanced, any other pending requester wins first (fairness).
- `done` is ignored in IDLE and RELEASE.
- Reset asserted mid-GRANT: `grant` clears asynchronously, with no RELEASE cycle and no `timeout` pulse.

## Timing
- Arbitration latency: `req` high before edge N in IDLE → `grant`/`sel` valid after edge N (1 cycle).
- Release: `done` high before edge M in GRANT → `grant`=0 after edge M. The next owner is granted at the earliest after edge M+2 (RELEASE at M+1, IDLE evaluation at M+2).
- Minimum owner-to-owner gap: 2 cycles with no grant (RELEASE, then IDLE).
- Forced release: with `req` held and no `done`, the grant is high for exactly `HOLD_MAX` cycles. `timeout` is high in the RELEASE cycle.
- `done` and hold expiry on the same edge: `done` wins, `timeout` stays 0.
- Reset deassertion: the first arbitration happens on the first edge after `reset` falls.

## Test plan
- Reset: drive `req`=11111, assert `reset` mid-GRANT → `grant`=00000, `sel`=000, `busy`=0 with no clock edge. After release, the first grant is 00001, `sel`=000.
- Round-robin: hold `req`=11111 and pulse `done` each grant → grant sequence 00001, 00010, 00100, 01000, 10000, 00001 with `sel` 000, 001, 010, 011, 100, 000. Each pair of grants is separated by 2 grant-less cycles.
- Pointer skip: `ptr`=3 and `req`=00101 → grant 00001, `sel`=000, then `ptr`=1. The next request pattern 00101 → grant 00100, `sel`=010.
- Timeout: `HOLD_MAX`=4, `req`=01000 held, `done`=0 → `grant`=01000 for exactly 4 cycles, then `timeout`=1 for 1 cycle with `sel`=011 retained.
- Collision: `HOLD_MAX`=4 with `done` asserted on the 4th grant cycle → `timeout` stays 0 and state goes to RELEASE.
- Request drop: owner 2 deasserts `req[2]` mid-grant → RELEASE on the next edge. `req`=00000 afterwards → state IDLE, `busy`=0, `sel` held at 010.

Source files
------------

// File: rtl/mux5_bus_arbiter.sv
// Round-robin owner sequencer for the 5-input ALU result-select mux.
// Registered one-hot grant and select code, with hold limit and a dead cycle between owners.
module mux5_bus_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       done,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } stateT;

  stateT      state;
  stateT      stateNxt;
  logic [4:0] grantNxt;
  logic [2:0] selNxt;
  logic       busyNxt;
  logic       timeoutNxt;
  logic [2:0] ptr;
  logic [2:0] ptrNxt;
  logic [3:0] cnt;
  logic [3:0] cntNxt;

  logic [2:0] winner;
  logic       found;
  logic [3:0] idx;
  logic       ownerReq;
  logic       holdDone;

  // Search ptr, ptr+1, ... modulo 5 for the first active request.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = 4'd0;
    for (int k = 0; k < 5; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && req[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  assign ownerReq = |(req & grant);
  assign holdDone = (cnt == 4'(HOLD_MAX));

  always_comb begin
    stateNxt   = state;
    grantNxt   = grant;
    selNxt     = sel;
    busyNxt    = busy;
    timeoutNxt = 1'b0;
    ptrNxt     = ptr;
    cntNxt     = cnt;
    unique case (state)
      IDLE: begin
        grantNxt = 5'd0;
        busyNxt  = 1'b0;
        if (found) begin
          stateNxt = GRANT;
          grantNxt = 5'd1 << winner;
          selNxt   = winner;
          busyNxt  = 1'b1;
          cntNxt   = 4'd1;
          ptrNxt   = (winner == 3'd4) ? 3'd0 : winner + 3'd1;
        end
      end
      GRANT: begin
        // An owner finishing or dropping out beats hold expiry.
        if (done || !ownerReq) begin
          stateNxt = RELEASE;
          grantNxt = 5'd0;
          busyNxt  = 1'b1;
          cntNxt   = 4'd0;
        end else if (holdDone) begin
          stateNxt   = RELEASE;
          grantNxt   = 5'd0;
          busyNxt    = 1'b1;
          timeoutNxt = 1'b1;
          cntNxt     = 4'd0;
        end else begin
          cntNxt = cnt + 4'd1;
        end
      end
      RELEASE: begin
        stateNxt = IDLE;
        grantNxt = 5'd0;
        busyNxt  = 1'b0;
      end
      default: begin
        stateNxt = IDLE;
        grantNxt = 5'd0;
        busyNxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 5'd0;
      sel     <= 3'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 3'd0;
      cnt     <= 4'd0;
    end else begin
      state   <= stateNxt;
      grant   <= grantNxt;
      sel     <= selNxt;
      busy    <= busyNxt;
      timeout <= timeoutNxt;
      ptr     <= ptrNxt;
      cnt     <= cntNxt;
    end
  end

endmodule
